// File: rtl/fetch_queue_pkg.sv
// Shared core definitions for fetch and decode: instruction/PC widths,
// the canonical NOP and the queue entry layout.
package fetch_queue_pkg;
    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam logic [INST_W-1:0] CORE_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch pair in, head/head+1 pair out.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              fetch_validA, fetch_validB;
    logic [INST_W-1:0] fetch_instA, fetch_instB;
    logic [PC_W-1:0]   fetch_pcA, fetch_pcB;
    logic              fetch_ready;

    logic [INST_W-1:0] instA, instB;
    logic [PC_W-1:0]   pcA, pcB;
    logic              validA, validB;
    logic              deq_ready;
    logic              flush;
    logic [CNT_W-1:0]  count;

    // queue side
    modport slave (
        input  fetch_validA, fetch_validB, fetch_instA, fetch_instB,
               fetch_pcA, fetch_pcB, deq_ready, flush,
        output fetch_ready, instA, instB, pcA, pcB, validA, validB, count
    );

    // fetch/decode side
    modport master (
        output fetch_validA, fetch_validB, fetch_instA, fetch_instB,
               fetch_pcA, fetch_pcB, deq_ready, flush,
        input  fetch_ready, instA, instB, pcA, pcB, validA, validB, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-wide in-order instruction queue between fetch and decode.
// Circular buffer with separate occupancy counter; outputs come from registered state only.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                DEPTH    = 8,
    parameter logic [INST_W-1:0] NOP_INST = CORE_NOP
) (
    input  logic clk,
    input  logic rst_n,
    fetch_queue_if.slave fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic             enq;
    logic [1:0]       enq_n, deq_n;
    logic [PTR_W-1:0] head_p1, tail_p1;

    // Room for a full pair is required before accepting anything; keeps
    // fetch_ready independent of deq_ready.
    assign fq.fetch_ready = (count <= CNT_W'(DEPTH - 2));
    assign fq.count       = count;

    assign enq     = fq.fetch_ready & fq.fetch_validA;
    assign enq_n   = enq ? (fq.fetch_validB ? 2'd2 : 2'd1) : 2'd0;
    assign deq_n   = fq.deq_ready ? (2'(fq.validA) + 2'(fq.validB)) : 2'd0;
    assign head_p1 = head + 1'b1;
    assign tail_p1 = tail + 1'b1;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= '{inst: fq.fetch_instA, pc: fq.fetch_pcA};
            if (fq.fetch_validB)
                mem[tail_p1] <= '{inst: fq.fetch_instB, pc: fq.fetch_pcB};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || fq.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    always_comb begin
        fq.validA = (count >= CNT_W'(1));
        fq.validB = (count >= CNT_W'(2));
        fq.instA  = NOP_INST;
        fq.pcA    = '0;
        fq.instB  = NOP_INST;
        fq.pcB    = '0;
        if (fq.validA) begin
            fq.instA = mem[head].inst;
            fq.pcA   = mem[head].pc;
        end
        if (fq.validB) begin
            fq.instB = mem[head_p1].inst;
            fq.pcB   = mem[head_p1].pc;
        end
    end
endmodule
